// File: rtl/sdram_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_rd_arbiter
// Purpose  : Round-robin arbiter sharing one Avalon-MM burst read port
//            between two requesters, one burst outstanding at a time.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_rd_arbiter #(
   parameter int ADDR_W  = 29,
   parameter int DATA_W  = 64,
   parameter int BURST_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               r0_read,
   input  logic [ADDR_W-1:0]  r0_address,
   input  logic [BURST_W-1:0] r0_burstcount,
   output logic               r0_waitrequest,
   output logic [DATA_W-1:0]  r0_readdata,
   output logic               r0_readdatavalid,
   input  logic               r1_read,
   input  logic [ADDR_W-1:0]  r1_address,
   input  logic [BURST_W-1:0] r1_burstcount,
   output logic               r1_waitrequest,
   output logic [DATA_W-1:0]  r1_readdata,
   output logic               r1_readdatavalid,
   output logic [ADDR_W-1:0]  sdram_address,
   output logic [BURST_W-1:0] sdram_burstcount,
   output logic               sdram_read,
   input  logic               sdram_waitrequest,
   input  logic [DATA_W-1:0]  sdram_readdata,
   input  logic               sdram_readdatavalid,
   output logic               busy,
   output logic               err_stray
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_ISSUE = 2'd1;
   localparam logic [1:0] c_DATA  = 2'd2;

   logic [1:0]         r_state;
   logic               r_read;
   logic [ADDR_W-1:0]  r_address;
   logic [BURST_W-1:0] r_burstcount;
   logic [BURST_W-1:0] r_remaining;
   logic               r_owner;
   logic               r_last_grant;
   logic               r_err_stray;

   logic               w_idle;
   logic               w_active;
   logic               w_grant0;
   logic               w_grant1;
   logic               w_accept;
   logic [ADDR_W-1:0]  w_addr;
   logic [BURST_W-1:0] w_bc;
   logic               w_beat;

   // On a tie the requester that was not granted last wins.
   assign w_idle   = (r_state == c_IDLE);
   assign w_active = (r_state == c_ISSUE) | (r_state == c_DATA);
   assign w_grant0 = w_idle & r0_read & (~r1_read | r_last_grant);
   assign w_grant1 = w_idle & r1_read & (~r0_read | ~r_last_grant);
   assign w_accept = w_grant0 | w_grant1;
   assign w_addr   = w_grant1 ? r1_address    : r0_address;
   assign w_bc     = w_grant1 ? r1_burstcount : r0_burstcount;
   assign w_beat   = w_active & sdram_readdatavalid & (r_remaining != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= c_IDLE;
         r_read       <= 1'b0;
         r_address    <= '0;
         r_burstcount <= '0;
         r_remaining  <= '0;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_err_stray  <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (sdram_readdatavalid) begin
                  r_err_stray <= 1'b1;
               end
               if (w_accept) begin
                  r_last_grant <= w_grant1;
                  // Zero-length bursts are acknowledged but never forwarded.
                  if (w_bc != '0) begin
                     r_address    <= w_addr;
                     r_burstcount <= w_bc;
                     r_remaining  <= w_bc;
                     r_owner      <= w_grant1;
                     r_read       <= 1'b1;
                     r_state      <= c_ISSUE;
                  end
               end
            end
            c_ISSUE: begin
               if (!sdram_waitrequest) begin
                  r_read  <= 1'b0;
                  r_state <= c_DATA;
               end
            end
            c_DATA: begin
               r_state <= c_DATA;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase

         if (w_beat) begin
            r_remaining <= r_remaining - BURST_W'(1);
            if (r_remaining == BURST_W'(1)) begin
               r_state <= c_IDLE;
               r_read  <= 1'b0;
            end
         end
      end
   end

   assign r0_waitrequest   = ~w_grant0;
   assign r1_waitrequest   = ~w_grant1;
   assign r0_readdata      = sdram_readdata;
   assign r1_readdata      = sdram_readdata;
   assign r0_readdatavalid = w_active & sdram_readdatavalid & ~r_owner;
   assign r1_readdatavalid = w_active & sdram_readdatavalid &  r_owner;
   assign sdram_address    = r_address;
   assign sdram_burstcount = r_burstcount;
   assign sdram_read       = r_read;
   assign busy             = ~w_idle;
   assign err_stray        = r_err_stray;

endmodule
`default_nettype wire

// File: tb/tb_sdram_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_rd_arbiter
// Purpose  : Scoreboard bench with a behavioural SDRAM port and requesters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_rd_arbiter;
   localparam int ADDR_W  = 29;
   localparam int DATA_W  = 64;
   localparam int BURST_W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic r0_read = 1'b0, r1_read = 1'b0;
   logic [ADDR_W-1:0] r0_address = '0, r1_address = '0;
   logic [BURST_W-1:0] r0_burstcount = '0, r1_burstcount = '0;
   logic r0_waitrequest, r1_waitrequest, r0_readdatavalid, r1_readdatavalid;
   logic [DATA_W-1:0] r0_readdata, r1_readdata;
   logic [ADDR_W-1:0] sdram_address;
   logic [BURST_W-1:0] sdram_burstcount;
   logic sdram_read;
   logic sdram_waitrequest = 1'b0;
   logic [DATA_W-1:0] sdram_readdata = '0;
   logic sdram_readdatavalid = 1'b0;
   logic busy, err_stray;

   sdram_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_read(r0_read), .r0_address(r0_address), .r0_burstcount(r0_burstcount),
      .r0_waitrequest(r0_waitrequest), .r0_readdata(r0_readdata), .r0_readdatavalid(r0_readdatavalid),
      .r1_read(r1_read), .r1_address(r1_address), .r1_burstcount(r1_burstcount),
      .r1_waitrequest(r1_waitrequest), .r1_readdata(r1_readdata), .r1_readdatavalid(r1_readdatavalid),
      .sdram_address(sdram_address), .sdram_burstcount(sdram_burstcount), .sdram_read(sdram_read),
      .sdram_waitrequest(sdram_waitrequest), .sdram_readdata(sdram_readdata),
      .sdram_readdatavalid(sdram_readdatavalid), .busy(busy), .err_stray(err_stray)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [DATA_W-1:0] q0[$];
   logic [DATA_W-1:0] q1[$];
   int grant_log[$];
   logic [ADDR_W-1:0] cq_a[$];
   logic [BURST_W-1:0] cq_bc[$];

   int tb_last = 1;
   logic [ADDR_W-1:0] exp_cmd_a = '0;
   logic [BURST_W-1:0] exp_cmd_bc = '0;
   int stall_mode = 0;
   int beat_gaps = 0;
   int stray_req = 0;
   int stray_done = 0;
   int read_seen = 0;
   int last_read_cycles = 0;

   function automatic logic [DATA_W-1:0] beat_data(input logic [ADDR_W-1:0] a, input int i);
      return {3'b000, a, 24'h000000, 8'(i)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s: got event expected none", name);
   endtask

   // Issues one request and holds it until the arbiter accepts it.
   task automatic do_req(input int id, input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] bc);
      int n;
      for (int i = 0; i < int'(bc); i++) begin
         if (id == 0) q0.push_back(beat_data(a, i));
         else         q1.push_back(beat_data(a, i));
      end
      if (id == 0) begin r0_address = a; r0_burstcount = bc; r0_read = 1'b1; end
      else         begin r1_address = a; r1_burstcount = bc; r1_read = 1'b1; end
      n = 0;
      forever begin
         @(negedge clk);
         if ((id == 0 ? r0_waitrequest : r1_waitrequest) == 1'b0) break;
         n++;
         if (n > 2000) begin
            fail_now($sformatf("req_timeout_r%0d", id));
            break;
         end
      end
      @(posedge clk); #1;
      if (id == 0) r0_read = 1'b0;
      else         r1_read = 1'b0;
   endtask

   task automatic rand_loop(input int id);
      for (int k = 0; k < 40; k++) begin
         repeat ($urandom_range(0, 4)) @(posedge clk);
         #1;
         do_req(id, ADDR_W'($urandom), BURST_W'($urandom_range(0, 6)));
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (q0.size() != 0 || q1.size() != 0 || cq_a.size() != 0) begin
         @(posedge clk);
         n++;
         if (n > 3000) begin
            fail_now({name, "_drain_timeout"});
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic pulse_reset();
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Arbitration and beat-routing monitor.
   initial forever begin
      int w;
      @(negedge clk);
      if (!rst_n) begin
         tb_last = 1;
      end else begin
         if (!r0_waitrequest && !r1_waitrequest) begin
            fail_now("both_granted");
         end else if (!r0_waitrequest || !r1_waitrequest) begin
            w = !r0_waitrequest ? 0 : 1;
            chk("grant_has_req", {63'd0, (w == 0) ? r0_read : r1_read}, 64'd1);
            if (r0_read && r1_read) chk("rr_winner", 64'(w), 64'(1 - tb_last));
            grant_log.push_back(w);
            tb_last = w;
            if (w == 0 && r0_burstcount != '0) begin exp_cmd_a = r0_address; exp_cmd_bc = r0_burstcount; end
            if (w == 1 && r1_burstcount != '0) begin exp_cmd_a = r1_address; exp_cmd_bc = r1_burstcount; end
         end
      end
      if (r0_readdatavalid && r1_readdatavalid) fail_now("both_beats_valid");
      if (sdram_readdatavalid) chk("readdata_bcast", r1_readdata, sdram_readdata);
      if (r0_readdatavalid) begin
         if (q0.size() == 0) fail_now("r0_unexpected_beat");
         else chk("r0_beat", r0_readdata, q0.pop_front());
      end
      if (r1_readdatavalid) begin
         if (q1.size() == 0) fail_now("r1_unexpected_beat");
         else chk("r1_beat", r1_readdata, q1.pop_front());
      end
   end

   // Behavioural SDRAM port: command hold checks, stalls and beat return.
   initial begin
      logic holding;
      logic was_read;
      int stall_left, beat_idx, read_cycles;
      logic [ADDR_W-1:0] hold_a;
      logic [BURST_W-1:0] hold_bc;
      holding = 1'b0; was_read = 1'b0; stall_left = 0; beat_idx = 0; read_cycles = 0;
      hold_a = '0; hold_bc = '0;
      forever begin
         @(negedge clk);
         if (rst_n && sdram_read) begin
            read_seen++;
            if (!holding) begin
               hold_a = sdram_address; hold_bc = sdram_burstcount; holding = 1'b1; read_cycles = 0;
            end else begin
               chk("cmd_hold_addr", 64'(sdram_address), 64'(hold_a));
               chk("cmd_hold_bc", 64'(sdram_burstcount), 64'(hold_bc));
            end
            read_cycles++;
            if (!sdram_waitrequest) begin
               chk("cmd_addr", 64'(sdram_address), 64'(exp_cmd_a));
               chk("cmd_bc", 64'(sdram_burstcount), 64'(exp_cmd_bc));
               if (cq_a.size() != 0) fail_now("cmd_while_outstanding");
               cq_a.push_back(sdram_address);
               cq_bc.push_back(sdram_burstcount);
               holding = 1'b0;
               last_read_cycles = read_cycles;
            end
         end else begin
            holding = 1'b0;
         end

         @(posedge clk); #1;
         if (sdram_read && !was_read)
            stall_left = (stall_mode == 2) ? 5 : (stall_mode == 1) ? int'($urandom_range(0, 3)) : 0;
         was_read = sdram_read;
         sdram_waitrequest = 1'b0;
         if (sdram_read && stall_left > 0) begin
            sdram_waitrequest = 1'b1;
            stall_left--;
         end
         sdram_readdatavalid = 1'b0;
         sdram_readdata = {$urandom, $urandom};
         if (stray_req != stray_done) begin
            sdram_readdatavalid = 1'b1;
            stray_done++;
         end else if (cq_a.size() != 0 && (beat_gaps == 0 || $urandom_range(0, 3) != 0)) begin
            sdram_readdatavalid = 1'b1;
            sdram_readdata = beat_data(cq_a[0], beat_idx);
            beat_idx++;
            if (beat_idx == int'(cq_bc[0])) begin
               void'(cq_a.pop_front());
               void'(cq_bc.pop_front());
               beat_idx = 0;
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int rs;
      logic busy_seen;
      int n;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_sdram_read", 64'(sdram_read), 64'd0);
      chk("rst_sdram_addr", 64'(sdram_address), 64'd0);
      chk("rst_sdram_bc", 64'(sdram_burstcount), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err_stray", 64'(err_stray), 64'd0);
      chk("rst_r0_wait", 64'(r0_waitrequest), 64'd1);
      chk("rst_r1_wait", 64'(r1_waitrequest), 64'd1);
      chk("rst_r0_valid", 64'(r0_readdatavalid), 64'd0);
      chk("rst_r1_valid", 64'(r1_readdatavalid), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Single request, no stall.
      do_req(0, 29'h100, 8'd4);
      drain("single");
      chk("single_cmd_cycles", 64'(last_read_cycles), 64'd1);
      chk("single_busy_after", 64'(busy), 64'd0);

      // Simultaneous requests twice after a fresh reset.
      pulse_reset();
      grant_log.delete();
      fork
         do_req(0, 29'h10, 8'd2);
         do_req(1, 29'h20, 8'd3);
      join
      drain("rr1");
      fork
         do_req(0, 29'h10, 8'd2);
         do_req(1, 29'h20, 8'd3);
      join
      drain("rr2");
      chk("rr_grants", 64'(grant_log.size()), 64'd4);
      if (grant_log.size() == 4) begin
         chk("rr_g0", 64'(grant_log[0]), 64'd0);
         chk("rr_g1", 64'(grant_log[1]), 64'd1);
         chk("rr_g2", 64'(grant_log[2]), 64'd0);
         chk("rr_g3", 64'(grant_log[3]), 64'd1);
      end

      // Five stall cycles during ISSUE.
      stall_mode = 2;
      do_req(0, 29'h2345, 8'd3);
      drain("stall");
      chk("stall_accept_cycle", 64'(last_read_cycles), 64'd6);
      stall_mode = 0;

      // Zero-length burst.
      rs = read_seen;
      busy_seen = 1'b0;
      do_req(1, 29'h55, 8'd0);
      repeat (5) begin
         @(negedge clk);
         busy_seen = busy_seen | busy;
      end
      chk("zero_busy", 64'(busy_seen), 64'd0);
      chk("zero_no_read", 64'(read_seen), 64'(rs));

      // Stray beat in IDLE.
      chk("stray_pre", 64'(err_stray), 64'd0);
      stray_req++;
      repeat (3) @(negedge clk);
      chk("stray_set", 64'(err_stray), 64'd1);
      repeat (5) @(negedge clk);
      chk("stray_sticky", 64'(err_stray), 64'd1);

      // Reset after two of eight beats.
      pulse_reset();
      chk("reset_clears_err", 64'(err_stray), 64'd0);
      do_req(0, 29'h777, 8'd8);
      n = 0;
      forever begin
         @(negedge clk); #1;
         if (q0.size() <= 6) break;
         n++;
         if (n > 200) begin fail_now("midrst_wait_timeout"); break; end
      end
      rst_n = 1'b0;
      q0.delete();
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_read", 64'(sdram_read), 64'd0);
      chk("midrst_addr", 64'(sdram_address), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drain("midrst");
      chk("midrst_err_stray", 64'(err_stray), 64'd1);

      // Randomized traffic with stalls and beat gaps.
      pulse_reset();
      stall_mode = 1;
      beat_gaps = 1;
      fork
         rand_loop(0);
         rand_loop(1);
      join
      drain("random");
      chk("random_q0_empty", 64'(q0.size()), 64'd0);
      chk("random_q1_empty", 64'(q1.size()), 64'd0);
      chk("random_no_stray", 64'(err_stray), 64'd0);
      chk("random_idle", 64'(busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
